ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
PS/2 device-to-host receiver that feeds the password-entry front end with validated 8-bit scan codes. It sits between the raw PS2_Clock/PS2_Data pins and the character-entry logic. It synchronises and filters the PS/2 lines, deframes 11-bit frames, checks parity, and strips F0 (break) and E0 (extended) prefixes. It emits one-cycle qualified code events plus a held last-make-code register for display.

Parameters:
FILTER_LEN, 4, system-clock cycles the synchronised PS2_Clock must be stable before a level change is accepted (glitch filter)
TIMEOUT_CYCLES, 10000, max system-clock cycles between PS/2 falling edges inside a frame before abort (200 us at 50 MHz)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
PS2_Clock  input  1  raw PS/2 clock from device, asynchronous
PS2_Data  input  1  raw PS/2 data from device, asynchronous
scan_code  output  8  code of last completed event, valid when scan_valid=1
scan_valid  output  1  one-cycle pulse: non-prefix code received
is_break  output  1  qualifies scan_valid: code was preceded by F0
is_extended  output  1  qualifies scan_valid: code was preceded by E0
held_code  output  8  last make code (is_break=0), held until next make
frame_error  output  1  one-cycle pulse: parity/stop error or timeout

Behaviour:
- Reset (synchronous, active-high): state=IDLE; scan_code=0x00, held_code=0x00; scan_valid, is_break, is_extended, frame_error=0; pending_break=pending_ext=0; filter and timeout counters cleared; synchroniser flops load 1.
- Sync: each pin passes through 2 flops. Filtered clock changes only after the synced clock holds its new value for FILTER_LEN consecutive cycles. Falling edge = filtered clock 1->0, a one-cycle internal strobe. Data is sampled from synced PS2_Data on that strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: edge with data=0 -> DATA, bit_cnt=0. Edge with data=1 -> stay in IDLE, no error.
  - DATA: each edge shifts data in LSB first, bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: edge latches the parity bit -> STOP.
  - STOP: edge evaluates the frame, then -> IDLE. Frame is good if stop bit=1 and (XOR of 8 data bits XOR parity)=1 (odd parity).
- Timeout: the counter runs in DATA/PARITY/STOP and clears on each edge. On reaching TIMEOUT_CYCLES: frame_error pulse, pending flags cleared, -> IDLE.
- Good frame, code 0xF0: pending_break=1, no output pulse.
- Good frame, code 0xE0: pending_ext=1, no output pulse.
- Good frame, any other code:
  - In the cycle after the stop-bit edge strobe: scan_code=code, scan_valid=1, is_break=pending_break, is_extended=pending_ext.
  - Both pending flags then clear.
  - If pending_break=0, held_code=code in the same cycle.
- Bad frame: frame_error pulses for 1 cycle, in the cycle after the stop edge strobe. Pending flags clear; scan_code and held_code keep their values.
- Pulse timing: scan_valid and frame_error are never both 1. Each is high exactly one cycle per event.
- is_break/is_extended hold their values until the next scan_valid.
- Consecutive prefixes: F0 then F0 leaves pending_break=1. E0,F0,code gives is_extended=1 and is_break=1.
- Reset mid-frame: the partial frame is discarded with no pulses. The receiver resynchronises on the next start bit.
- Host-to-device transmission is out of scope; the pins are input-only.

Decomposition:
- Shared package ps2_pkg:
  - FSM state typedef (IDLE/DATA/PARITY/STOP)
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_FRAME_BITS=11
- One sub-module: ps2_line_filter. It holds the 2-flop synchroniser, the FILTER_LEN stability counter and the falling-edge strobe, is instantiated for the clock line, and outputs filtered_clk, fall_strobe and synced data.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at 12 kHz -> one scan_valid pulse; scan_code=0x1C, is_break=0, is_extended=0, held_code=0x1C.
- Frames F0 then 1C -> no pulse after F0; one pulse after 1C with scan_code=0x1C and is_break=1; held_code unchanged from its prior value.
- Frames E0,F0,75 -> single pulse: scan_code=0x75, is_extended=1, is_break=1; next plain frame 0x16 -> pulse with both flags 0, held_code=0x16.
- Frame 0x1C with parity bit 1 -> frame_error for 1 cycle, no scan_valid, scan_code/held_code unchanged; following good 0x32 -> scan_valid, scan_code=0x32.
- Frame stopped after 4 data bits, line idle for TIMEOUT_CYCLES -> frame_error pulse exactly once; next full 0x24 frame decodes correctly.
- 2-cycle low glitches on PS2_Clock (FILTER_LEN=4) during IDLE and mid-frame -> no extra bits shifted, decoded 0x1C correct; reset asserted mid-frame -> all outputs at reset values, no pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    // Deframer states: waiting for start bit, shifting data, parity, stop.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_line_filter.sv
// Synchronises the raw PS/2 pins, deglitches the clock line and produces a
// one-cycle strobe on each accepted falling edge of the PS/2 clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_clk,
    input  logic raw_data,
    output logic filtered_clk,
    output logic fall_strobe,
    output logic synced_data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [CW-1:0] stable_cnt;
    logic          synced_clk;

    assign synced_clk  = clk_sync[1];
    assign synced_data = data_sync[1];

    // Two-flop synchronisers; both idle high like the PS/2 bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], raw_clk};
            data_sync <= {data_sync[0], raw_data};
        end
    end

    // Accept a clock level change only after FILTER_LEN consecutive cycles
    // of disagreement; a falling acceptance fires the edge strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            filtered_clk <= 1'b1;
            stable_cnt   <= '0;
            fall_strobe  <= 1'b0;
        end else begin
            fall_strobe <= 1'b0;
            if (synced_clk != filtered_clk) begin
                if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                    filtered_clk <= synced_clk;
                    stable_cnt   <= '0;
                    fall_strobe  <= ~synced_clk;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks odd parity
// and stop bit, folds F0/E0 prefixes into qualifier flags on the next code.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       PS2_Clock,
    input  logic       PS2_Data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic [7:0] held_code,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Only the edge strobe drives the deframer; the filtered level is unused.
    logic filt_clk_unused;
    logic edge_strobe;
    logic bit_in;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clock        (clock),
        .reset        (reset),
        .raw_clk      (PS2_Clock),
        .raw_data     (PS2_Data),
        .filtered_clk (filt_clk_unused),
        .fall_strobe  (edge_strobe),
        .synced_data  (bit_in)
    );

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] timeout_cnt;
    logic          pending_break;
    logic          pending_ext;

    // Frame deframer, prefix tracking and registered output events.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            timeout_cnt   <= '0;
            pending_break <= 1'b0;
            pending_ext   <= 1'b0;
            scan_code     <= '0;
            held_code     <= '0;
            scan_valid    <= 1'b0;
            is_break      <= 1'b0;
            is_extended   <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE) begin
                timeout_cnt <= '0;
                // A high bit while idle is not a start bit and is ignored.
                if (edge_strobe && !bit_in) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (edge_strobe) begin
                timeout_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= {bit_in, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= bit_in;
                        state      <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (bit_in && odd_parity_ok(shift_reg, parity_bit)) begin
                            if (shift_reg == PS2_BREAK) begin
                                pending_break <= 1'b1;
                            end else if (shift_reg == PS2_EXT) begin
                                pending_ext <= 1'b1;
                            end else begin
                                scan_code     <= shift_reg;
                                scan_valid    <= 1'b1;
                                is_break      <= pending_break;
                                is_extended   <= pending_ext;
                                pending_break <= 1'b0;
                                pending_ext   <= 1'b0;
                                if (!pending_break) begin
                                    held_code <= shift_reg;
                                end
                            end
                        end else begin
                            frame_error   <= 1'b1;
                            pending_break <= 1'b0;
                            pending_ext   <= 1'b0;
                        end
                    end
                endcase
            end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Device stopped clocking mid-frame: abort and drop prefixes.
                frame_error   <= 1'b1;
                pending_break <= 1'b0;
                pending_ext   <= 1'b0;
                timeout_cnt   <= '0;
                state         <= IDLE;
            end else begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames on the pins, predicts events
// from frame contents and prefix history, and checks outputs every cycle.
module tb_ps2_scancode_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 400;
    localparam int HALF    = 40;

    logic       clock;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       is_break;
    logic       is_extended;
    logic [7:0] held_code;
    logic       frame_error;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .PS2_Clock   (ps2_clk),
        .PS2_Data    (ps2_dat),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .held_code   (held_code),
        .frame_error (frame_error)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_q;
    always @(posedge clock) rst_q <= reset;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // Event word: {is_error, is_break, is_extended, code}
    logic [10:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    bit checking = 0;

    // Prefix history seen by the model.
    bit pend_b = 0;
    bit pend_e = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model of what one complete frame must produce.
    task automatic model_frame(input logic [7:0] code, input bit good);
        if (!good) begin
            exp_q.push_back({1'b1, 2'b00, 8'h00});
            pend_b = 0;
            pend_e = 0;
        end else if (code == 8'hF0) begin
            pend_b = 1;
        end else if (code == 8'hE0) begin
            pend_e = 1;
        end else begin
            exp_q.push_back({1'b0, pend_b, pend_e, code});
            pend_b = 0;
            pend_e = 0;
        end
    endtask

    // Model output registers, updated from consumed events.
    logic [7:0] m_scan = 0;
    logic [7:0] m_held = 0;
    logic       m_brk  = 0;
    logic       m_ext  = 0;

    // Single compare process, on the falling edge.
    always @(negedge clock) begin
        logic [10:0] e;
        if (checking) begin
            if (rst_q) begin
                m_scan = 0; m_held = 0; m_brk = 0; m_ext = 0;
                chk("reset_valid", {31'd0, scan_valid}, 0);
                chk("reset_error", {31'd0, frame_error}, 0);
            end else begin
                if (scan_valid && frame_error) chk("pulse_overlap", 1, 0);
                if (scan_valid || frame_error) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, scan_valid, frame_error}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", {31'd0, frame_error}, {31'd0, e[10]});
                        if (!e[10]) begin
                            m_scan = e[7:0];
                            m_brk  = e[9];
                            m_ext  = e[8];
                            if (!e[9]) m_held = e[7:0];
                        end
                    end
                end
            end
            chk("scan_code", {24'd0, scan_code}, {24'd0, m_scan});
            chk("held_code", {24'd0, held_code}, {24'd0, m_held});
            chk("is_break", {31'd0, is_break}, {31'd0, m_brk});
            chk("is_extended", {31'd0, is_extended}, {31'd0, m_ext});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One bit: data set while clock high, then a low half-period.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_cycles(HALF / 2);
            ps2_clk = 1'b0;
            wait_cycles(2);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2 - 2);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic idle_and_check(input int n);
        ps2_dat = 1'b1;
        wait_cycles(n);
        chk("missing_pulse", exp_q.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par,
                              input bit bad_stop, input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        model_frame(code, !bad_par && !bad_stop);
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
        idle_and_check(3 * HALF);
    endtask

    task automatic expect_now(input string name, input logic [7:0] act, input logic [7:0] exp);
        @(negedge clock);
        chk(name, {24'd0, act}, {24'd0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cycles(5);
        checking = 1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(20);

        // Plain make code.
        send_frame(8'h1C, 0, 0, 0);
        expect_now("lit_1c_scan", scan_code, 8'h1C);
        expect_now("lit_1c_held", held_code, 8'h1C);

        // Break of 1C: held code stays.
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        expect_now("lit_brk_flag", {7'd0, is_break}, 8'h01);

        // Extended break, then plain make.
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        expect_now("lit_75_scan", scan_code, 8'h75);
        expect_now("lit_75_flags", {6'd0, is_break, is_extended}, 8'h03);
        expect_now("lit_75_held", held_code, 8'h1C);
        send_frame(8'h16, 0, 0, 0);
        expect_now("lit_16_held", held_code, 8'h16);

        // Parity error, then good code.
        send_frame(8'h1C, 1, 0, 0);
        expect_now("lit_perr_scan", scan_code, 8'h16);
        send_frame(8'h32, 0, 0, 0);
        expect_now("lit_32_scan", scan_code, 8'h32);

        // Stop-bit error.
        send_frame(8'h4D, 0, 1, 0);

        // Truncated frame: start plus 4 data bits, then silence.
        exp_q.push_back({1'b1, 2'b00, 8'h00});
        pend_b = 0; pend_e = 0;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        idle_and_check(TIMEOUT + 100);
        send_frame(8'h24, 0, 0, 0);
        expect_now("lit_24_held", held_code, 8'h24);

        // Glitches while idle, then a glitchy frame.
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            wait_cycles(2);
            ps2_clk = 1'b1;
            wait_cycles(15);
        end
        send_frame(8'h1C, 0, 0, 1);
        expect_now("lit_glitch_scan", scan_code, 8'h1C);

        // Reset in the middle of a frame.
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        reset = 1'b1;
        pend_b = 0; pend_e = 0;
        wait_cycles(3);
        chk("lit_rst_scan", {24'd0, scan_code}, 0);
        chk("lit_rst_held", {24'd0, held_code}, 0);
        reset = 1'b0;
        idle_and_check(HALF);
        send_frame(8'h24, 0, 0, 0);

        // Randomised frames, including prefixes and corrupted frames.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] code;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      code = 8'hF0;
            else if (sel == 1) code = 8'hE0;
            else               code = 8'($urandom_range(0, 255));
            send_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 3) == 0);
        end

        wait_cycles(10);
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
